vend_ctrl: RTL and testbench

//  Multi-product vending controller. Accumulates credit from coin pulses (units of 0.5 yuan),

---
 rtl/vend_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_vend_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit accumulation, priced product selection with a dispense
// handshake, and coin-by-coin change/refund through a return handshake.
module vend_ctrl #(
  parameter int CW         = 5,
  parameter int MAX_CREDIT = 20,
  parameter int PRICE0     = 4,
  parameter int PRICE1     = 3,
  parameter int PRICE2     = 5,
  parameter int PRICE3     = 6,
  parameter int TIMEOUT    = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_half_i,
  input  logic          coin_one_i,
  input  logic          sel_valid_i,
  input  logic [1:0]    sel_id_i,
  input  logic          cancel_i,
  output logic          vend_req_o,
  output logic [1:0]    vend_id_o,
  input  logic          vend_ack_i,
  output logic          change_req_o,
  output logic          change_one_o,
  input  logic          change_ack_i,
  output logic          coin_reject_o,
  output logic          sel_deny_o,
  output logic [CW-1:0] credit_o
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW:0]   CEILING    = (CW+1)'(MAX_CREDIT);
  localparam logic [CW-1:0] CREDIT_ZERO = {CW{1'b0}};
  localparam logic [TW-1:0] TIMER_ZERO  = {TW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;

  function automatic logic [CW-1:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = CW'(PRICE0);
      2'd1:    price_of = CW'(PRICE1);
      2'd2:    price_of = CW'(PRICE2);
      2'd3:    price_of = CW'(PRICE3);
      default: price_of = CW'(PRICE3);
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          vend_req_q, vend_req_d;
  logic [1:0]    vend_id_q, vend_id_d;
  logic          change_req_q, change_req_d;
  logic          change_one_q, change_one_d;
  logic          coin_reject_q, coin_reject_d;
  logic          sel_deny_q, sel_deny_d;

  logic          coin_s;
  logic [1:0]    coin_amt_s;
  logic [CW:0]   sum_s;
  logic          coin_fits_s;
  logic [CW-1:0] price_s;
  logic          afford_s;
  logic          activity_s;
  logic [CW-1:0] ret_amt_s;
  logic          coin_rej_s;
  logic          sel_deny_s;

  // The coin pair encodes its own amount: {one, half} = 2*one + half.
  assign coin_s      = coin_half_i | coin_one_i;
  assign coin_amt_s  = {coin_one_i, coin_half_i};
  assign sum_s       = {1'b0, credit_q} + {{(CW-1){1'b0}}, coin_amt_s};
  assign coin_fits_s = (sum_s <= CEILING);
  assign price_s     = price_of(sel_id_i);
  assign afford_s    = (credit_q >= price_s);
  assign activity_s  = coin_s | sel_valid_i | cancel_i;
  assign ret_amt_s   = change_one_q ? CW'(2) : CW'(1);

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= CREDIT_ZERO;
      timer_q       <= TIMER_ZERO;
      vend_req_q    <= 1'b0;
      vend_id_q     <= 2'd0;
      change_req_q  <= 1'b0;
      change_one_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_deny_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      vend_req_q    <= vend_req_d;
      vend_id_q     <= vend_id_d;
      change_req_q  <= change_req_d;
      change_one_q  <= change_one_d;
      coin_reject_q <= coin_reject_d;
      sel_deny_q    <= sel_deny_d;
    end
  end

  // Next state, credit, idle timer and the refuse decisions for this cycle's inputs.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    timer_d    = TIMER_ZERO;
    coin_rej_s = 1'b0;
    sel_deny_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_deny_s = sel_valid_i;
        if (coin_s) begin
          credit_d = sum_s[CW-1:0];
          state_d  = ST_CREDIT;
        end else begin
          credit_d = CREDIT_ZERO;
        end
      end
      ST_CREDIT: begin
        if (cancel_i) begin
          coin_rej_s = coin_s;
          state_d    = ST_CHANGE;
        end else if (sel_valid_i && afford_s) begin
          coin_rej_s = coin_s;
          credit_d   = credit_q - price_s;
          state_d    = ST_VEND;
        end else begin
          sel_deny_s = sel_valid_i;
          if (coin_s && coin_fits_s) begin
            credit_d = sum_s[CW-1:0];
          end else begin
            coin_rej_s = coin_s;
          end
          // Any keypad or coin activity restarts the inactivity refund timer.
          if (activity_s) begin
            timer_d = TIMER_ZERO;
          end else if (timer_q == TIMER_LAST) begin
            state_d = ST_CHANGE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      ST_VEND: begin
        coin_rej_s = coin_s;
        sel_deny_s = sel_valid_i;
        if (vend_ack_i) begin
          state_d = (credit_q != CREDIT_ZERO) ? ST_CHANGE : ST_IDLE;
        end else begin
          state_d = ST_VEND;
        end
      end
      ST_CHANGE: begin
        coin_rej_s = coin_s;
        if (credit_q == CREDIT_ZERO) begin
          state_d = ST_IDLE;
        end else if (change_req_q && change_ack_i) begin
          if (credit_q <= ret_amt_s) begin
            credit_d = CREDIT_ZERO;
            state_d  = ST_IDLE;
          end else begin
            credit_d = credit_q - ret_amt_s;
          end
        end else begin
          credit_d = credit_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = CREDIT_ZERO;
      end
    endcase
  end

  // Output values for the next cycle, derived from the upcoming state and credit.
  always_comb begin
    vend_req_d    = (state_d == ST_VEND);
    vend_id_d     = ((state_q == ST_CREDIT) && (state_d == ST_VEND)) ? sel_id_i : vend_id_q;
    // An accepted return drops the request for one cycle before the next coin.
    change_req_d  = (state_d == ST_CHANGE) && (credit_d != CREDIT_ZERO) &&
                    !(change_req_q && change_ack_i);
    change_one_d  = change_req_d && (credit_d >= CW'(2));
    coin_reject_d = coin_rej_s;
    sel_deny_d    = sel_deny_s;
  end

  assign vend_req_o    = vend_req_q;
  assign vend_id_o     = vend_id_q;
  assign change_req_o  = change_req_q;
  assign change_one_o  = change_one_q;
  assign coin_reject_o = coin_reject_q;
  assign sel_deny_o    = sel_deny_q;
  assign credit_o      = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios with fixed expectations plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_vend_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_half, coin_one, sel_valid, cancel, vend_ack, change_ack;
  logic [1:0] sel_id;
  logic       vend_req, change_req, change_one, coin_reject, sel_deny;
  logic [1:0] vend_id;
  logic [4:0] credit;

  int n_cmp = 0;
  int n_bad = 0;

  vend_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .coin_half_i(coin_half), .coin_one_i(coin_one),
    .sel_valid_i(sel_valid), .sel_id_i(sel_id), .cancel_i(cancel),
    .vend_req_o(vend_req), .vend_id_o(vend_id), .vend_ack_i(vend_ack),
    .change_req_o(change_req), .change_one_o(change_one), .change_ack_i(change_ack),
    .coin_reject_o(coin_reject), .sel_deny_o(sel_deny), .credit_o(credit)
  );

  always #5 clk = ~clk;

  // Reference model: modes, integer credit, and a queue of coins still owed on refund.
  localparam int M_IDLE = 0, M_CREDIT = 1, M_VEND = 2, M_REFUND = 3;
  int m_mode, m_credit, m_idle, m_vid;
  bit m_vreq, m_creq, m_cone, m_rej, m_deny;
  int m_q[$];
  int price[4] = '{4, 3, 5, 6};

  task automatic model_reset();
    m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_vid = 0;
    m_vreq = 0; m_creq = 0; m_cone = 0; m_rej = 0; m_deny = 0;
    m_q.delete();
  endtask

  task automatic start_refund();
    int c;
    c = m_credit;
    m_q.delete();
    m_mode = M_REFUND;
    while (c >= 2) begin m_q.push_back(2); c -= 2; end
    if (c == 1) m_q.push_back(1);
    if (m_q.size() == 0) m_mode = M_IDLE;
  endtask

  task automatic model_step(input bit h, o, sv, input bit [1:0] id, input bit c, va, ca);
    int a; bit coin; bit acked;
    a = int'(h) + 2 * int'(o);
    coin = h | o;
    acked = 0; m_rej = 0; m_deny = 0;
    case (m_mode)
      M_IDLE: begin
        m_deny = sv;
        if (coin) begin m_credit = a; m_mode = M_CREDIT; m_idle = 0; end
      end
      M_CREDIT: begin
        if (c) begin
          m_rej = coin; start_refund();
        end else if (sv && m_credit >= price[id]) begin
          m_rej = coin; m_credit -= price[id]; m_vid = int'(id); m_mode = M_VEND;
        end else begin
          m_deny = sv;
          if (coin) begin
            if (m_credit + a <= 20) m_credit += a; else m_rej = 1;
          end
          if (coin || sv) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == TO) begin m_idle = 0; start_refund(); end
          end
        end
      end
      M_VEND: begin
        m_rej = coin; m_deny = sv;
        if (va) begin
          if (m_credit > 0) start_refund(); else m_mode = M_IDLE;
        end
      end
      default: begin
        m_rej = coin;
        if (m_creq && ca) begin
          acked = 1;
          m_credit -= m_q.pop_front();
          if (m_q.size() == 0) m_mode = M_IDLE;
        end
      end
    endcase
    m_vreq = (m_mode == M_VEND);
    m_creq = (m_mode == M_REFUND) && !acked;
    m_cone = m_creq && (m_q.size() > 0) && (m_q[0] == 2);
  endtask

  task automatic clear_inputs();
    coin_half = 0; coin_one = 0; sel_valid = 0; sel_id = 2'd0;
    cancel = 0; vend_ack = 0; change_ack = 0;
  endtask

  // One clock: inputs sampled at the edge, model advanced, outputs settled 1 time unit later.
  task automatic drive(input bit h, o, sv, input bit [1:0] id, input bit c, va, ca);
    coin_half = h; coin_one = o; sel_valid = sv; sel_id = id;
    cancel = c; vend_ack = va; change_ack = ca;
    @(posedge clk);
    model_step(h, o, sv, id, c, va, ca);
    #1;
    clear_inputs();
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    n_cmp++; if ({vend_req, vend_id, change_req, change_one, coin_reject, sel_deny} !== 7'd0) begin n_bad++; $display("FAIL reset_outputs: got %b want 0000000", {vend_req, vend_id, change_req, change_one, coin_reject, sel_deny}); end
    n_cmp++; if (credit !== 5'd0) begin n_bad++; $display("FAIL reset_credit: got %0d want 0", credit); end
    @(negedge clk); rst = 0;
    drive(0, 0, 1, 2'd0, 1, 1, 1);
    n_cmp++; if ({sel_deny, change_req, vend_req, credit} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin n_bad++; $display("FAIL idle_sel_deny: got deny=%b creq=%b vreq=%b credit=%0d want 1 0 0 0", sel_deny, change_req, vend_req, credit); end
  endtask

  task automatic test_exact_vend();
    do_reset();
    drive(0, 1, 0, 2'd0, 0, 0, 0);
    n_cmp++; if (credit !== 5'd2) begin n_bad++; $display("FAIL exact_credit1: got %0d want 2", credit); end
    drive(0, 1, 0, 2'd0, 0, 1, 0);
    n_cmp++; if (credit !== 5'd4) begin n_bad++; $display("FAIL exact_credit2: got %0d want 4", credit); end
    drive(0, 0, 1, 2'd0, 0, 0, 0);
    n_cmp++; if ({vend_req, vend_id, credit} !== {1'b1, 2'd0, 5'd0}) begin n_bad++; $display("FAIL exact_vend: got req=%b id=%0d credit=%0d want 1 0 0", vend_req, vend_id, credit); end
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    n_cmp++; if ({vend_req, coin_reject} !== 2'b11) begin n_bad++; $display("FAIL exact_hold: got req=%b rej=%b want 1 1", vend_req, coin_reject); end
    drive(0, 0, 0, 2'd0, 0, 1, 0);
    n_cmp++; if ({vend_req, change_req, credit} !== {1'b0, 1'b0, 5'd0}) begin n_bad++; $display("FAIL exact_ack: got vreq=%b creq=%b credit=%0d want 0 0 0", vend_req, change_req, credit); end
    idle_cycle();
    n_cmp++; if (change_req !== 1'b0) begin n_bad++; $display("FAIL exact_nochange: got %b want 0", change_req); end
  endtask

  task automatic test_vend_change();
    do_reset();
    drive(0, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 1, 2'd1, 0, 0, 0);
    n_cmp++; if ({vend_req, vend_id, credit} !== {1'b1, 2'd1, 5'd1}) begin n_bad++; $display("FAIL chg_vend: got req=%b id=%0d credit=%0d want 1 1 1", vend_req, vend_id, credit); end
    drive(0, 0, 0, 2'd0, 0, 1, 0);
    n_cmp++; if ({vend_req, change_req, change_one} !== 3'b010) begin n_bad++; $display("FAIL chg_req: got vreq=%b creq=%b one=%b want 0 1 0", vend_req, change_req, change_one); end
    drive(0, 0, 0, 2'd0, 0, 0, 1);
    n_cmp++; if ({change_req, credit} !== {1'b0, 5'd0}) begin n_bad++; $display("FAIL chg_done: got creq=%b credit=%0d want 0 0", change_req, credit); end
    idle_cycle();
    n_cmp++; if (change_req !== 1'b0) begin n_bad++; $display("FAIL chg_idle: got %b want 0", change_req); end
  endtask

  task automatic test_deny_cancel();
    do_reset();
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 1, 2'd0, 0, 0, 0);
    n_cmp++; if ({sel_deny, vend_req, credit} !== {1'b1, 1'b0, 5'd1}) begin n_bad++; $display("FAIL deny_pulse: got deny=%b vreq=%b credit=%0d want 1 0 1", sel_deny, vend_req, credit); end
    idle_cycle();
    n_cmp++; if (sel_deny !== 1'b0) begin n_bad++; $display("FAIL deny_single: got %b want 0", sel_deny); end
    drive(0, 1, 0, 2'd0, 1, 0, 0);
    n_cmp++; if ({change_req, change_one, coin_reject, credit} !== {1'b1, 1'b0, 1'b1, 5'd1}) begin n_bad++; $display("FAIL cancel_req: got creq=%b one=%b rej=%b credit=%0d want 1 0 1 1", change_req, change_one, coin_reject, credit); end
    drive(0, 0, 0, 2'd0, 0, 0, 1);
    n_cmp++; if ({change_req, credit} !== {1'b0, 5'd0}) begin n_bad++; $display("FAIL cancel_done: got creq=%b credit=%0d want 0 0", change_req, credit); end
  endtask

  task automatic test_ceiling();
    do_reset();
    drive(1, 1, 0, 2'd0, 0, 0, 0);
    n_cmp++; if (credit !== 5'd3) begin n_bad++; $display("FAIL both_coins: got %0d want 3", credit); end
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 2'd0, 0, 0, 0);
    n_cmp++; if (credit !== 5'd19) begin n_bad++; $display("FAIL ceil_19: got %0d want 19", credit); end
    drive(0, 1, 0, 2'd0, 0, 0, 0);
    n_cmp++; if ({coin_reject, credit} !== {1'b1, 5'd19}) begin n_bad++; $display("FAIL ceil_reject: got rej=%b credit=%0d want 1 19", coin_reject, credit); end
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    n_cmp++; if ({coin_reject, credit} !== {1'b0, 5'd20}) begin n_bad++; $display("FAIL ceil_20: got rej=%b credit=%0d want 0 20", coin_reject, credit); end
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    n_cmp++; if ({coin_reject, credit} !== {1'b1, 5'd20}) begin n_bad++; $display("FAIL ceil_full: got rej=%b credit=%0d want 1 20", coin_reject, credit); end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(0, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 1, 0, 2'd0, 0, 0, 0);
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) idle_cycle();
    n_cmp++; if ({change_req, credit} !== {1'b0, 5'd5}) begin n_bad++; $display("FAIL to_early: got creq=%b credit=%0d want 0 5", change_req, credit); end
    idle_cycle();
    n_cmp++; if ({change_req, change_one} !== 2'b11) begin n_bad++; $display("FAIL to_first: got creq=%b one=%b want 1 1", change_req, change_one); end
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    n_cmp++; if ({change_req, coin_reject, credit} !== {1'b1, 1'b1, 5'd5}) begin n_bad++; $display("FAIL to_hold: got creq=%b rej=%b credit=%0d want 1 1 5", change_req, coin_reject, credit); end
    drive(0, 0, 0, 2'd0, 0, 0, 1);
    n_cmp++; if ({change_req, credit} !== {1'b0, 5'd3}) begin n_bad++; $display("FAIL to_ret1: got creq=%b credit=%0d want 0 3", change_req, credit); end
    idle_cycle();
    n_cmp++; if ({change_req, change_one} !== 2'b11) begin n_bad++; $display("FAIL to_second: got creq=%b one=%b want 1 1", change_req, change_one); end
    drive(0, 0, 0, 2'd0, 0, 0, 1);
    idle_cycle();
    n_cmp++; if ({change_req, change_one, credit} !== {1'b1, 1'b0, 5'd1}) begin n_bad++; $display("FAIL to_third: got creq=%b one=%b credit=%0d want 1 0 1", change_req, change_one, credit); end
    drive(0, 0, 0, 2'd0, 0, 0, 1);
    idle_cycle();
    n_cmp++; if ({change_req, credit} !== {1'b0, 5'd0}) begin n_bad++; $display("FAIL to_done: got creq=%b credit=%0d want 0 0", change_req, credit); end
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    n_cmp++; if (credit !== 5'd1) begin n_bad++; $display("FAIL to_idle_coin: got %0d want 1", credit); end
  endtask

  task automatic test_reset_mid_vend();
    do_reset();
    drive(0, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 1, 1, 2'd1, 0, 0, 0);
    n_cmp++; if (vend_req !== 1'b1) begin n_bad++; $display("FAIL rv_vend: got %b want 1", vend_req); end
    #2 rst = 1;
    model_reset();
    #1;
    n_cmp++; if ({vend_req, vend_id, change_req, credit} !== {1'b0, 2'd0, 1'b0, 5'd0}) begin n_bad++; $display("FAIL rv_async: got vreq=%b id=%0d creq=%b credit=%0d want 0 0 0 0", vend_req, vend_id, change_req, credit); end
    @(negedge clk); rst = 0;
    drive(0, 0, 1, 2'd1, 0, 1, 1);
    n_cmp++; if ({sel_deny, vend_req, change_req, credit} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin n_bad++; $display("FAIL rv_idle: got deny=%b vreq=%b creq=%b credit=%0d want 1 0 0 0", sel_deny, vend_req, change_req, credit); end
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    do_reset();
    for (int blk = 0; blk < 150; blk++) begin
      bit quiet;
      int len;
      quiet = ($urandom_range(0, 3) == 0);
      len = quiet ? int'($urandom_range(4, TO + 4)) : int'($urandom_range(5, 25));
      for (int k = 0; k < len; k++) begin
        bit h, o, sv, c;
        bit [1:0] id;
        h  = !quiet && ($urandom_range(0, 7) == 0);
        o  = !quiet && ($urandom_range(0, 5) == 0);
        sv = !quiet && ($urandom_range(0, 7) == 0);
        c  = !quiet && ($urandom_range(0, 49) == 0);
        id = 2'($urandom_range(0, 3));
        drive(h, o, sv, id, c, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
        got = {vend_req, vend_id, change_req, change_one, coin_reject, sel_deny, credit};
        exp = {m_vreq, 2'(m_vid), m_creq, m_cone, m_rej, m_deny, 5'(m_credit)};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL random blk%0d cyc%0d: got vreq/id/creq/one/rej/deny/credit=%b want %b", blk, k, got, exp);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_exact_vend();
    test_vend_change();
    test_deny_cancel();
    test_ceiling();
    test_timeout();
    test_reset_mid_vend();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
